// File: rtl/bcd_multi_digit_counter.sv
// rtl/bcd_multi_digit_counter.sv - multi-digit BCD up/down counter with load, clear and wrap/saturate
// Counts once per rising edge of the step strobe; digit 0 is the least significant nibble.
module bcd_multi_digit_counter #(
    parameter int                        NUM_DIGITS  = 4,
    parameter logic [4*NUM_DIGITS-1:0]   RESET_VALUE = 'h0001,
    parameter bit                        WRAP_EN     = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      step,
    input  logic                      up_down,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    input  logic                      clear,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic                      wrap,
    output logic                      at_max,
    output logic                      at_min
);

    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0] digits_q, digits_d;
    logic         wrap_q, wrap_d;
    logic         step_prev_q;
    logic         step_rise;

    logic [W-1:0] inc_val, dec_val, clamp_val;
    logic         carry, borrow, all_nine, all_zero;

    assign step_rise = step & ~step_prev_q;

    always_comb begin
        inc_val   = digits_q;
        dec_val   = digits_q;
        clamp_val = '0;
        carry     = 1'b1;
        borrow    = 1'b1;
        all_nine  = 1'b1;
        all_zero  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (digits_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (digits_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
            clamp_val[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
            all_nine = all_nine & (digits_q[4*i +: 4] == 4'd9);
            all_zero = all_zero & (digits_q[4*i +: 4] == 4'd0);
        end
    end

    // At the limits the ripple result already equals the wrapped value, so only saturation needs gating.
    always_comb begin
        digits_d = digits_q;
        wrap_d   = 1'b0;
        if (clear) begin
            digits_d = '0;
        end else if (load) begin
            digits_d = clamp_val;
        end else if (step_rise) begin
            if (up_down) begin
                if (!all_nine || WRAP_EN) begin
                    digits_d = inc_val;
                end
                wrap_d = all_nine & WRAP_EN;
            end else begin
                if (!all_zero || WRAP_EN) begin
                    digits_d = dec_val;
                end
                wrap_d = all_zero & WRAP_EN;
            end
        end
    end

    // step_prev resets high so a strobe held through reset is not counted until it is re-pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q    <= RESET_VALUE;
            wrap_q      <= 1'b0;
            step_prev_q <= 1'b1;
        end else begin
            digits_q    <= digits_d;
            wrap_q      <= wrap_d;
            step_prev_q <= step;
        end
    end

    assign digits = digits_q;
    assign wrap   = wrap_q;
    assign at_max = all_nine;
    assign at_min = all_zero;

endmodule

// File: tb/tb_bcd_multi_digit_counter.sv
// tb/tb_bcd_multi_digit_counter.sv - self-checking bench for bcd_multi_digit_counter
module tb_bcd_multi_digit_counter;

    logic        clk = 1'b0;
    logic        reset, step, up_down, load, clear;
    logic [15:0] load_value;
    logic [15:0] digits_w, digits_s;
    logic        wrap_w, wrap_s, at_max_w, at_max_s, at_min_w, at_min_s;

    int checks = 0;
    int errors = 0;

    // reference model: plain decimal integers
    int m_val_w, m_val_s;
    bit m_wrap_w, m_wrap_s, m_prev;

    typedef struct {
        logic        cl, ld, st, up;
        logic [15:0] lv;
        logic [15:0] exp_d;
        logic        exp_w, exp_max, exp_min;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    bcd_multi_digit_counter #(.NUM_DIGITS(4), .RESET_VALUE(16'h0001), .WRAP_EN(1'b1)) dut_w (
        .clk(clk), .reset(reset), .step(step), .up_down(up_down), .load(load),
        .load_value(load_value), .clear(clear), .digits(digits_w), .wrap(wrap_w),
        .at_max(at_max_w), .at_min(at_min_w)
    );

    bcd_multi_digit_counter #(.NUM_DIGITS(4), .RESET_VALUE(16'h0001), .WRAP_EN(1'b0)) dut_s (
        .clk(clk), .reset(reset), .step(step), .up_down(up_down), .load(load),
        .load_value(load_value), .clear(clear), .digits(digits_s), .wrap(wrap_s),
        .at_max(at_max_s), .at_min(at_min_s)
    );

    function automatic int clamp_dec(input logic [15:0] lv);
        int r = 0;
        int p = 1;
        for (int i = 0; i < 4; i++) begin
            int n = int'((lv >> (4 * i)) & 16'hF);
            if (n > 9) n = 9;
            r += n * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r = r | (16'(v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val_w = 1; m_val_s = 1; m_wrap_w = 0; m_wrap_s = 0; m_prev = 1;
    endtask

    task automatic model_step(input bit cl, input bit ld, input bit st, input bit up, input logic [15:0] lv);
        bit rise = st && !m_prev;
        m_prev   = st;
        m_wrap_w = 0;
        m_wrap_s = 0;
        if (cl) begin
            m_val_w = 0; m_val_s = 0;
        end else if (ld) begin
            m_val_w = clamp_dec(lv); m_val_s = clamp_dec(lv);
        end else if (rise) begin
            if (up) begin
                if (m_val_w == 9999) begin m_val_w = 0; m_wrap_w = 1; end else m_val_w++;
                if (m_val_s != 9999) m_val_s++;
            end else begin
                if (m_val_w == 0) begin m_val_w = 9999; m_wrap_w = 1; end else m_val_w--;
                if (m_val_s != 0) m_val_s--;
            end
        end
    endtask

    // drive just after an edge, update the model on the next edge, sample 1ns later
    task automatic apply(input bit cl, input bit ld, input bit st, input bit up, input logic [15:0] lv);
        clear = cl; load = ld; step = st; up_down = up; load_value = lv;
        @(posedge clk);
        model_step(cl, ld, st, up, lv);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_digits_w"}, digits_w, to_bcd(m_val_w));
        check({tag, "_wrap_w"},   wrap_w,   m_wrap_w);
        check({tag, "_max_w"},    at_max_w, m_val_w == 9999);
        check({tag, "_min_w"},    at_min_w, m_val_w == 0);
        check({tag, "_digits_s"}, digits_s, to_bcd(m_val_s));
        check({tag, "_wrap_s"},   wrap_s,   m_wrap_s);
    endtask

    initial begin
        reset = 1'b1; step = 0; up_down = 1; load = 0; clear = 0; load_value = '0;
        model_reset();
        #23;
        check("reset_digits", digits_w, 16'h0001);
        check("reset_wrap",   wrap_w,   1'b0);
        check("reset_at_min", at_min_w, 1'b0);
        check("reset_at_max", at_max_w, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        //               cl ld st up  lv       exp_d    w  max min
        tbl.push_back('{0, 1, 0, 1, 16'h0009, 16'h0009, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 16'h0000, 16'h0010, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 16'h0000, 16'h0010, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 16'h0000, 16'h0010, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 16'h0000, 16'h0010, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 16'h0000, 16'h0010, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 16'h0000, 16'h0010, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 16'h0000, 16'h0011, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 16'h99F9, 16'h9999, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 16'h0000, 16'h0000, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 16'h0000, 16'h9999, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 0, 16'h0100, 16'h0100, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 16'h0000, 16'h0099, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 16'h0000, 16'h0099, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 16'h1234, 16'h0000, 0, 0, 1});
        tbl.push_back('{0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].cl, tbl[i].ld, tbl[i].st, tbl[i].up, tbl[i].lv);
            check($sformatf("vec%0d_digits", i), digits_w, tbl[i].exp_d);
            check($sformatf("vec%0d_wrap", i),   wrap_w,   tbl[i].exp_w);
            check($sformatf("vec%0d_at_max", i), at_max_w, tbl[i].exp_max);
            check($sformatf("vec%0d_at_min", i), at_min_w, tbl[i].exp_min);
        end

        // saturating instance holds at both limits
        apply(0, 1, 0, 1, 16'h9999);
        apply(0, 0, 1, 1, 16'h0000);
        check("sat_up_digits", digits_s, 16'h9999);
        check("sat_up_wrap",   wrap_s,   1'b0);
        apply(0, 1, 0, 0, 16'h0000);
        apply(0, 0, 1, 0, 16'h0000);
        check("sat_dn_digits", digits_s, 16'h0000);
        check("sat_dn_wrap",   wrap_s,   1'b0);
        check("wrap_dn_digits", digits_w, 16'h9999);

        // reset mid-count with step held high
        apply(0, 1, 1, 1, 16'h0456);
        check("pre_reset_digits", digits_w, 16'h0456);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_reset_digits", digits_w, 16'h0001);
        check("async_reset_digits_s", digits_s, 16'h0001);
        @(negedge clk);
        reset = 1'b0;
        apply(0, 0, 1, 1, 16'h0000);
        apply(0, 0, 1, 1, 16'h0000);
        check("held_after_reset", digits_w, 16'h0001);
        apply(0, 0, 0, 1, 16'h0000);
        apply(0, 0, 1, 1, 16'h0000);
        check("reapplied_step", digits_w, 16'h0002);
        check_model("post_reset");

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            bit cl = ($urandom_range(0, 19) == 0);
            bit ld = ($urandom_range(0, 9) == 0);
            bit st = $urandom_range(0, 1);
            bit up = $urandom_range(0, 1);
            logic [15:0] lv = 16'($urandom);
            if ($urandom_range(0, 7) == 0) lv = ($urandom_range(0, 1) != 0) ? 16'h9999 : 16'h0000;
            apply(cl, ld, st, up, lv);
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
